// File: rtl/mux8t1_rr_arbiter.sv
// rtl/mux8t1_rr_arbiter.sv - round-robin arbiter driving the mux8t1 select for 8 requesters
// Optional macro ARB_LOCK_EN adds a lock input that suspends the hold limit for the current owner.
module mux8t1_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
`ifdef ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       busy,
  output logic       preempt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] MAX_HOLD_C   = 8'(MAX_HOLD);
  localparam bit         HOLD_LIMITED = (MAX_HOLD != 0);

  state_t     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       preempt_q, preempt_d;
  logic [2:0] last_q, last_d;
  logic [7:0] hold_q, hold_d;

  logic       lock_act;
  logic       pick_found;
  logic [2:0] pick_idx;
  logic [2:0] cand;
  logic       owner_req;
  logic       others;
  logic       limit_hit;

`ifdef ARB_LOCK_EN
  assign lock_act = lock;
`else
  assign lock_act = 1'b0;
`endif

  // Search starts one past the previous owner so every pending requester is served in turn.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 3'd0;
    cand       = 3'd0;
    for (int k = 0; k < 8; k++) begin
      cand = last_q + 3'(k + 1);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign owner_req = req[sel_q];
  assign others    = |(req & ~gnt_q);
  assign limit_hit = HOLD_LIMITED && (hold_q >= MAX_HOLD_C) && !lock_act;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    preempt_d = 1'b0;
    last_d    = last_q;
    hold_d    = hold_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_d   = 8'(1) << pick_idx;
          sel_d   = pick_idx;
          busy_d  = 1'b1;
          hold_d  = 8'd1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          gnt_d   = 8'h00;
          busy_d  = 1'b0;
          last_d  = sel_q;
          state_d = IDLE;
        end else if (limit_hit && others) begin
          gnt_d     = 8'h00;
          busy_d    = 1'b0;
          last_d    = sel_q;
          preempt_d = 1'b1;
          state_d   = IDLE;
        end else if (!limit_hit && hold_q != 8'hFF) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 8'h00;
      sel_q     <= 3'd0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
      last_q    <= 3'd7;
      hold_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      preempt_q <= preempt_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_mux8t1_rr_arbiter.sv
// tb/tb_mux8t1_rr_arbiter.sv - directed self-checking bench for mux8t1_rr_arbiter (MAX_HOLD=4)
module tb_mux8t1_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       lock;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       preempt;

  int total;
  int bad;

  mux8t1_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
`ifdef ARB_LOCK_EN
    .lock    (lock),
`endif
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int owners [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    req   = 8'h00;
    lock  = 1'b0;
    tick;
    tick;
    check("rst_gnt", 32'(gnt), 32'h00);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_preempt", 32'(preempt), 32'd0);
    rst = 1'b0;

    // single request, no combinational path before the edge
    req = 8'h08;
    #2;
    check("single_nocomb", 32'(gnt), 32'h00);
    tick;
    check("single_gnt", 32'(gnt), 32'h08);
    check("single_sel", 32'(sel), 32'd3);
    check("single_busy", 32'(busy), 32'd1);
    req = 8'h00;
    tick;
    check("single_rel_gnt", 32'(gnt), 32'h00);
    check("single_rel_busy", 32'(busy), 32'd0);
    check("single_rel_sel", 32'(sel), 32'd3);

    // mid-grant asynchronous reset
    req = 8'h10;
    tick;
    check("mid_gnt", 32'(gnt), 32'h10);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_gnt", 32'(gnt), 32'h00);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_sel", 32'(sel), 32'd0);
    req = 8'h00;
    tick;
    tick;
    rst = 1'b0;
    req = 8'h01;
    tick;
    check("post_rst_gnt", 32'(gnt), 32'h01);

    // full rotation with all requests held
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      if (i != 0) begin
        tick;
        check($sformatf("rot%0d_gnt", i), 32'(gnt), 32'(8'(1) << owners[i]));
        check($sformatf("rot%0d_sel", i), 32'(sel), 32'(owners[i]));
        check($sformatf("rot%0d_pre0", i), 32'(preempt), 32'd0);
      end
      for (int h = 0; h < 3; h++) begin
        tick;
        check($sformatf("rot%0d_hold", i), 32'(gnt), 32'(8'(1) << owners[i]));
      end
      tick;
      check($sformatf("rot%0d_gap", i), 32'(gnt), 32'h00);
      check($sformatf("rot%0d_pre", i), 32'(preempt), 32'd1);
      check($sformatf("rot%0d_busy", i), 32'(busy), 32'd0);
    end
    req = 8'h00;
    tick;
    check("rot_end_gnt", 32'(gnt), 32'h00);
    check("rot_end_pre", 32'(preempt), 32'd0);

    // release and fairness
    req = 8'h20;
    tick;
    check("fair_own5", 32'(gnt), 32'h20);
    req = 8'h00;
    tick;
    check("fair_rel_gnt", 32'(gnt), 32'h00);
    check("fair_rel_busy", 32'(busy), 32'd0);
    req = 8'h44;
    tick;
    check("fair_first", 32'(gnt), 32'h40);
    check("fair_first_sel", 32'(sel), 32'd6);
    req = 8'h04;
    tick;
    check("fair_gap", 32'(gnt), 32'h00);
    check("fair_gap_pre", 32'(preempt), 32'd0);
    tick;
    check("fair_second", 32'(gnt), 32'h04);
    req = 8'h00;
    tick;
    check("fair_end", 32'(gnt), 32'h00);

    // lone requester keeps the bus past the hold limit
    req = 8'h02;
    tick;
    check("lone_gnt", 32'(gnt), 32'h02);
    for (int c = 0; c < 20; c++) begin
      tick;
      check($sformatf("lone_hold%0d", c), 32'(gnt), 32'h02);
      check($sformatf("lone_pre%0d", c), 32'(preempt), 32'd0);
    end

`ifdef ARB_LOCK_EN
    // owner 1 locked while requester 0 waits
    req  = 8'h03;
    lock = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick;
      check($sformatf("lock_hold%0d", c), 32'(gnt), 32'h02);
      check($sformatf("lock_pre%0d", c), 32'(preempt), 32'd0);
    end
    lock = 1'b0;
    tick;
    check("unlock_pre", 32'(preempt), 32'd1);
    check("unlock_gnt", 32'(gnt), 32'h00);
    tick;
    check("unlock_next", 32'(gnt), 32'h01);
    check("unlock_pre_clr", 32'(preempt), 32'd0);
`endif

    req = 8'h00;
    tick;
    check("final_rel", 32'(gnt), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux8t1_rr_arbiter.md
Name: mux8t1_rr_arbiter

Overview:
- Round-robin arbiter that shares the 8:1 x 4-bit mux (mux8t1) output bus among 8 requesters.
- Each requester i drives mux input x<i> and raises req[i].
- The arbiter grants one requester at a time and drives the mux `sel` so that bus `o` carries the owner's data.
- The block sits directly in front of mux8t1, with `sel` wired straight to the mux select.

Parameters:
- MAX_HOLD, default 8: maximum consecutive grant cycles while other requests are pending. Range 0..255; 0 = unlimited.

Ports:
- clk      input   1  system clock, rising edge
- rst      input   1  asynchronous, active-high reset
- req      input   8  request lines; bit i = requester i
- gnt      output  8  one-hot grant; all-zero when bus idle
- sel      output  3  mux8t1 select; index of current/last owner
- busy     output  1  high while a grant is active
- preempt  output  1  one-cycle pulse when a grant is revoked by the hold limit

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. All registers clear immediately when rst goes high, including in the middle of a grant.
- Reset values:
  - state = IDLE
  - gnt = 8'h00, sel = 3'd0, busy = 0, preempt = 0
  - last = 3'd7, so the first search starts at index 0
  - hold_cnt = 8'd0
- All outputs are registered. There is no combinational path from req to any output.
- State IDLE:
  - If req != 0, the next edge selects the first set bit searching from (last+1) mod 8 upward with wrap-around.
  - On that edge: gnt <= onehot(idx), sel <= idx, busy <= 1, hold_cnt <= 1, state -> GRANT.
  - Latency from req sampled high to gnt high is 1 cycle.
  - If req == 0, stay in IDLE. sel keeps its last value so the mux output stays stable.
- State GRANT (owner = sel):
  - Release: if req[sel] == 0, the next edge sets gnt <= 0, busy <= 0, last <= sel, state -> IDLE.
  - Preempt: if req[sel] == 1, MAX_HOLD != 0, hold_cnt == MAX_HOLD, and any other req bit is set, the next edge sets gnt <= 0, busy <= 0, last <= sel, preempt <= 1, state -> IDLE.
  - Hold with no competitor: if hold_cnt == MAX_HOLD and no other request is pending, keep the grant. hold_cnt saturates and preempt is not asserted.
  - Otherwise hold_cnt <= hold_cnt + 1, saturating at 255.
- Turnaround gap: every release or preempt leaves at least one IDLE cycle with gnt == 0 before the next grant.
- Requests are level-sensitive:
  - A requester that has been preempted but still holds req is re-arbitrated in normal round-robin order.
  - It is not granted again until every other pending requester has been served.
- Simultaneous events:
  - If the owner drops req in the same cycle the limit is hit, this is a release and preempt stays 0.
  - New requests arriving during GRANT are only evaluated in IDLE.
- preempt is high for exactly one cycle and is cleared on the following edge.
- Invariants: gnt is always one-hot or zero. When busy == 1, gnt == onehot(sel).

Optional Feature:
- Macro: ARB_LOCK_EN.
- When ARB_LOCK_EN is defined:
  - An extra port is added: `lock  input  1`.
  - While the owner is in GRANT and lock == 1, the hold limit is ignored. The grant persists until req[sel] drops and preempt never fires.
  - lock is ignored in IDLE.
  - When lock deasserts with hold_cnt >= MAX_HOLD and others pending, preemption occurs on the next edge.
- When ARB_LOCK_EN is undefined: the lock port does not exist and the hold limit always applies.

Test Plan:
- Mid-grant reset: raise rst asynchronously during a grant -> gnt=00, busy=0, sel=0 immediately. After release, req=8'h01 -> gnt=8'h01 one cycle later (last was reset to 7).
- Single request: req=8'h08 -> gnt=8'h08, sel=3, busy=1 on the first edge after req is sampled. mux o = x3 value 4'h3.
- All-request rotation: req=8'hFF held, MAX_HOLD=4 -> owners in order 0,1,...,7,0. Each owner holds 4 cycles, then preempt pulses and one idle cycle follows (5-cycle period).
- Release and fairness: owner 5 drops req -> next edge gnt=00, busy=0. Then req=8'h44 (bits 2 and 6) -> grant goes to 6, then 2.
- No competitor: req=8'h02 alone for 20 cycles with MAX_HOLD=4 -> gnt stays 8'h02, preempt stays 0, hold_cnt saturates.
- ARB_LOCK_EN: owner 1 with lock=1 and req=8'h03 for 10 cycles -> no preempt. Drop lock -> preempt=1 next edge, then gnt=8'h01 after the idle cycle.
